seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_scan_driver_hex7_decode.sv | 14 +
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment display driver.
//   - SEG_HEX   : 16-entry active-high segment patterns (bit order gfedcba)
//   - SEG_BLANK : active-high "all segments off" pattern
//   - SEG_A..G  : bit index of each segment inside a pattern
//   - seg_polarity(pattern, active_low): converts an active-high pattern to pin level
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                              input logic       active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex7_decode.sv
// hex7_decode: combinational hex nibble to active-high 7-segment pattern.
// Ports:
//   nibble  in  4  hex digit 0..F
//   pattern out 7  active-high segments, bit0=a .. bit6=g
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a bank of hex 7-segment digits.
// A prescaler lights each digit for SCAN_DIV clocks; the value is double
// buffered so the display only changes at a frame boundary. Supports per-digit
// decimal points and optional leading-zero blanking.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   value        4*NUM_DIGITS hex nibbles, nibble k = digit k (digit 0 = LSD)
//   dp_in        decimal-point request per digit
//   load         one-cycle strobe capturing value/dp_in
//   blank_lz     level enable for leading-zero blanking
//   seg, dp, an  registered segment / decimal point / digit-enable pins
//   frame_done   one-cycle pulse after the last digit's slot ends
// Optional feature: define SEG_SCAN_BLINK_EN to add parameter BLINK_FRAMES and
// input blink_mask; masked digits go dark during alternate blink periods.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_cnt;
  logic [DIG_W-1:0]        dig;
  logic [4*NUM_DIGITS-1:0] act_val, pend_val;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic                    pend_flag;
  logic                    tick, wrap;

  logic [NUM_DIGITS-1:0]   lz_mask, an_next, blink_vec;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_lz, cur_blink, zero_above, blank_now;
  logic [6:0]              raw_pat;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (dig == DIG_LAST);

  // Prescaler and digit index; a tick on the last digit is the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      dig     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick)
        dig <= (dig == DIG_LAST) ? '0 : dig + DIG_W'(1);
    end
  end

  // Double buffer. A load landing on the boundary tick bypasses the pending
  // buffer so it is shown in the very next frame instead of one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val   <= '0;
      act_dp    <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else if (load && wrap) begin
      act_val   <= value;
      act_dp    <= dp_in;
      pend_flag <= 1'b0;
    end else begin
      if (wrap && pend_flag) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] frame_cnt;
  logic            blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + BF_W'(1);
      end
    end
  end

  assign blink_vec = blink_phase ? blink_mask : '0;
`else
  assign blink_vec = '0;
`endif

  // Leading-zero mask is built from the top digit down: a digit is a leading
  // zero only while every digit above it is also a zero with no decimal point.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    cur_blink  = 1'b0;
    an_next    = '0;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (act_val[4*k +: 4] == 4'h0) && !act_dp[k];
      lz_mask[k] = zero_above && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig == DIG_W'(k)) begin
        cur_nib    = act_val[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_lz     = lz_mask[k];
        cur_blink  = blink_vec[k];
        an_next[k] = 1'b1;
      end
    end
  end

  hex7_decode u_decode (
    .nibble  (cur_nib),
    .pattern (raw_pat)
  );

  assign blank_now = (blank_lz && cur_lz) || cur_blink;

  // Output register; a blanked digit keeps its anode enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= seg_polarity(SEG_BLANK, POL);
      dp         <= POL;
      an         <= {NUM_DIGITS{POL}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_polarity(blank_now ? SEG_BLANK : raw_pat, POL);
      dp         <= POL ^ (cur_dp && !blank_now);
      an         <= an_next ^ {NUM_DIGITS{POL}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver with
// NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1 (all pins active-low).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dpIn;
  logic        load;
  logic        blankLz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frameDone;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blinkMask = 4'b0000;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dpIn),
    .load       (load),
    .blank_lz   (blankLz),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (blinkMask),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frameDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle load pulse, driven at a falling edge.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dpIn  = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Advance to the falling edge where frame_done is seen, with a cycle budget.
  task automatic waitFrame();
    int n = 0;
    while (frameDone !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_wait", 32'(frameDone), 32'd1);
  endtask

  // Called at the falling edge where frame_done is high. Checks the following
  // 16 cycles: digit i/4 lit, pattern from expSeg (digit 0 in low 7 bits),
  // dp pin from expDp, frame_done only on the last cycle. Optional loads are
  // injected at cycle offsets la1/la2 (-1 = none).
  task automatic checkFrame(input string tag, input logic [27:0] expSeg, input logic [3:0] expDp,
                            input int la1, input logic [15:0] v1, input logic [3:0] d1,
                            input int la2, input logic [15:0] v2, input logic [3:0] d2);
    for (int i = 0; i < 16; i++) begin
      int d;
      d = i / 4;
      if (i == la1) begin
        value = v1; dpIn = d1; load = 1'b1;
      end else if (i == la2) begin
        value = v2; dpIn = d2; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("%s_an%0d", tag, i), 32'(an), 32'(4'b1111 ^ (4'b0001 << d)));
      checkOutput($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(expSeg[7*d +: 7]));
      checkOutput($sformatf("%s_dp%0d", tag, i), 32'(dp), 32'(expDp[d]));
      checkOutput($sformatf("%s_fd%0d", tag, i), 32'(frameDone), (i == 15) ? 32'd1 : 32'd0);
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0000; dpIn = 4'b0000; blankLz = 1'b0;

    @(negedge clk);
    checkOutput("rst_an",  32'(an),  32'h0F);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_dp",  32'(dp),  32'd1);
    checkOutput("rst_fd",  32'(frameDone), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst3_an", 32'(an), 32'h0F);
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rel_an",  32'(an),  32'h0E);
    checkOutput("rel_seg", 32'(seg), 32'h40);
    checkOutput("rel_dp",  32'(dp),  32'd1);

    // 12AF becomes visible after the first boundary: F,A,2,1 on digits 0..3.
    applyStimulus(16'h12AF, 4'b0000);
    waitFrame();
    // Two loads mid-frame: display unchanged now, last load wins next frame.
    checkFrame("scan", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111,
               3, 16'h1111, 4'b0000, 5, 16'h2222, 4'b0000);
    // Load on the exact boundary tick goes straight to the active buffer.
    checkFrame("dbuf", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111,
               15, 16'h0005, 4'b0000, -1, 16'h0000, 4'b0000);
    checkFrame("bnd", {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111,
               2, 16'h0040, 4'b0000, -1, 16'h0000, 4'b0000);

    // Leading-zero blanking: digits 3,2 dark; then a dp on digit 3 lights all.
    blankLz = 1'b1;
    checkFrame("lz", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111,
               4, 16'h0040, 4'b1000, -1, 16'h0000, 4'b0000);
    checkFrame("lzdp", {7'h40, 7'h40, 7'h19, 7'h40}, 4'b0111,
               -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000);

    // Reset mid-frame must drop a pending load.
    blankLz = 1'b0;
    applyStimulus(16'h9999, 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_an",  32'(an),  32'h0F);
    checkOutput("rstmid_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    waitFrame();
    checkFrame("rstdisc", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111,
               -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
